spart_transmit: RTL and testbench
=================================

Name: spart_transmit

Overview:
- Transmit half of the SPART serial port. Accepts one byte from the processor bus and serialises it onto TxD as 8N1: start bit 0, 8 data bits LSB-first, stop bit 1.
- Bit timing comes from the shared baud-rate generator's Enable pulse, which runs at 16x the baud rate.
- Double-buffered: one holding register plus one shift register. This lets the driver queue the next byte while the current one shifts, giving back-to-back frames with no idle gap.

Parameters:
- DATA_BITS, 8, data bits per frame.
- OVERSAMPLE, 16, Enable pulses per bit time.

Ports:
- clk  in  1  system clock, single domain.
- rst  in  1  asynchronous, active-high reset.
- Enable  in  1  one-clk-wide 16x baud tick from the baud generator.
- IOCS  in  1  chip select for SPART bus accesses.
- IORW  in  1  1 = read, 0 = write.
- IOADDR  in  2  register select; 2'b00 = transmit/receive data register.
- DATA  in  DATA_BITS  write data from the bus interface.
- TxD  out  1  serial output; idles high.
- TBR  out  1  transmit buffer ready: 1 = holding register empty.

Behaviour:
- Reset is asynchronous and active-high:
  - TxD=1, TBR=1.
  - State=IDLE; tick counter, bit counter, hold_buf and shift_buf all 0.
  - Reset mid-frame aborts the frame: TxD is forced to 1 immediately, and the queued byte is discarded.
- Write strobe: wr = IOCS & ~IORW & (IOADDR==2'b00).
  - wr while TBR=1: hold_buf<=DATA, hold_full<=1.
  - wr while TBR=0: ignored. Buffers are not corrupted.
  - Reads (IORW=1) and other addresses never affect this block.
- TBR = ~hold_full, registered.
- States: IDLE, START, DATA, STOP.
  - IDLE:
    - TxD=1.
    - If hold_full: shift_buf<=hold_buf, hold_full<=0, tick<=0, state<=START.
    - This transfer does not wait for Enable.
  - START: TxD=0.
  - DATA:
    - TxD=shift_buf[0].
    - On each bit end: shift_buf shifts right, bit index+1.
    - After bit DATA_BITS-1 ends: state<=STOP.
  - STOP:
    - TxD=1.
    - At bit end, if hold_full: reload from hold_buf, clear hold_full, go to START (no idle gap).
    - Otherwise go to IDLE.
- Bit end: Enable & (tick==OVERSAMPLE-1).
  - tick increments only on Enable and wraps to 0 at bit end.
  - Each bit therefore lasts exactly OVERSAMPLE Enable pulses.
- Enable low: all counters and state hold. TxD holds its current level.
- Latency, from wr sampled at edge N with IDLE and TBR=1:
  - TBR=0 after edge N.
  - Transfer at edge N+1: TxD=0 and TBR=1 after edge N+1.
- Simultaneous transfer and wr: TBR is still 0 in that cycle, so the wr is ignored. The driver must poll TBR.
- TxD is driven from a flop; no combinational glitches.
- Counter widths: tick is clog2(OVERSAMPLE); bit index is clog2(DATA_BITS).

Decomposition:
- spart_pkg holds:
  - tx_state_t enum {IDLE, START, DATA, STOP};
  - localparam ADDR_DATA = 2'b00;
  - default OVERSAMPLE and DATA_BITS.
- No sub-module. The FSM, counters and buffers live in one module of about 150 lines.

Test Plan:
- Reset, Enable tied high, one wr of 0xA5 → TxD levels 0,1,0,1,0,0,1,0,1,1, each held exactly 16 clks. Frame = 160 clks, then TxD stays 1 and TBR stays 1.
- wr 0x55, then wr 0xAA as soon as TBR=1 → TBR high again 1 clk after each transfer. The second frame's start bit immediately follows the first stop bit. Total 320 clks with no extra high time.
- wr 0x11, wr 0x22, then wr 0x33 while TBR=0 → 0x33 is dropped. Only 0x11 then 0x22 appear on TxD.
- Enable pulsing every 4th clk, wr 0x3C → every bit lasts 64 clks. TxD never changes on a clk without Enable, except at the initial IDLE→START transition.
- rst asserted 50 clks into a 0xFF frame with a byte queued → TxD=1 and TBR=1 asynchronously. After release the line stays idle and no frame is sent.
- IORW=1 with IOADDR=00, and IORW=0 with IOADDR=01, with IOCS=1 → TBR stays 1 and TxD stays 1.

Source files
------------

// File: rtl/spart_pkg.sv
// Shared definitions for the SPART serial port blocks.
package spart_pkg;

  // Default frame geometry: 8 data bits, 16 Enable ticks per bit time.
  localparam int unsigned DATA_BITS_DEF  = 8;
  localparam int unsigned OVERSAMPLE_DEF = 16;

  // Bus register select for the transmit/receive data register.
  localparam logic [1:0] ADDR_DATA = 2'b00;

  // Transmitter FSM encoding. Prefixed because the bus data port is named DATA.
  typedef logic [1:0] tx_state_t;
  localparam tx_state_t TX_IDLE  = 2'd0;
  localparam tx_state_t TX_START = 2'd1;
  localparam tx_state_t TX_DATA  = 2'd2;
  localparam tx_state_t TX_STOP  = 2'd3;

endpackage

// File: rtl/spart_transmit.sv
// SPART transmitter: double-buffered 8N1 serialiser timed by a 16x baud Enable tick.
module spart_transmit
  import spart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = DATA_BITS_DEF,
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 Enable,
  input  logic                 IOCS,
  input  logic                 IORW,
  input  logic [1:0]           IOADDR,
  input  logic [DATA_BITS-1:0] DATA,
  output logic                 TxD,
  output logic                 TBR
);

  localparam int unsigned TICK_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int unsigned BIT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  tx_state_t             state_q, state_d;
  logic [TICK_W-1:0]     tick_q, tick_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [DATA_BITS-1:0]  hold_buf_q, hold_buf_d;
  logic [DATA_BITS-1:0]  shift_buf_q, shift_buf_d;
  logic                  hold_full_q, hold_full_d;
  logic                  txd_q, txd_d;
  logic                  wr;
  logic                  bit_end;

  assign wr      = IOCS & ~IORW & (IOADDR == ADDR_DATA);
  assign bit_end = Enable & (tick_q == TICK_LAST);

  // Next-state: FSM, oversample/bit counters, buffers and the registered line level.
  always_comb begin
    state_d     = state_q;
    tick_d      = tick_q;
    bit_d       = bit_q;
    hold_buf_d  = hold_buf_q;
    shift_buf_d = shift_buf_q;
    hold_full_d = hold_full_q;
    txd_d       = txd_q;

    if (Enable) begin
      tick_d = bit_end ? '0 : tick_q + 1'b1;
    end

    case (state_q)
      TX_IDLE: begin
        // Holding-to-shift transfer does not wait for Enable.
        tick_d = '0;
        txd_d  = 1'b1;
        if (hold_full_q) begin
          shift_buf_d = hold_buf_q;
          hold_full_d = 1'b0;
          bit_d       = '0;
          state_d     = TX_START;
          txd_d       = 1'b0;
        end
      end
      TX_START: begin
        if (bit_end) begin
          bit_d   = '0;
          state_d = TX_DATA;
          txd_d   = shift_buf_q[0];
        end
      end
      TX_DATA: begin
        if (bit_end) begin
          shift_buf_d = shift_buf_q >> 1;
          if (bit_q == BIT_LAST) begin
            state_d = TX_STOP;
            txd_d   = 1'b1;
          end else begin
            bit_d = bit_q + 1'b1;
            txd_d = shift_buf_d[0];
          end
        end
      end
      TX_STOP: begin
        if (bit_end) begin
          if (hold_full_q) begin
            // Queued byte follows the stop bit directly: no idle gap.
            shift_buf_d = hold_buf_q;
            hold_full_d = 1'b0;
            bit_d       = '0;
            state_d     = TX_START;
            txd_d       = 1'b0;
          end else begin
            state_d = TX_IDLE;
            txd_d   = 1'b1;
          end
        end
      end
      default: begin
        state_d = TX_IDLE;
        txd_d   = 1'b1;
      end
    endcase

    // Writes only land in an empty holding register; a transfer needs it full, so no overlap.
    if (wr && !hold_full_q) begin
      hold_buf_d  = DATA;
      hold_full_d = 1'b1;
    end
  end

  // State registers; reset aborts any frame and drops the queued byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= TX_IDLE;
      tick_q      <= '0;
      bit_q       <= '0;
      hold_buf_q  <= '0;
      shift_buf_q <= '0;
      hold_full_q <= 1'b0;
      txd_q       <= 1'b1;
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_d;
      bit_q       <= bit_d;
      hold_buf_q  <= hold_buf_d;
      shift_buf_q <= shift_buf_d;
      hold_full_q <= hold_full_d;
      txd_q       <= txd_d;
    end
  end

  assign TxD = txd_q;
  assign TBR = ~hold_full_q;

endmodule

// File: tb/tb_spart_transmit.sv
// Randomised self-checking bench for spart_transmit against a frame-level line model.
module tb_spart_transmit;

  localparam int OS    = 16;
  localparam int DB    = 8;
  localparam int FRAME = (DB + 2) * OS;

  logic        clk;
  logic        rst;
  logic        Enable;
  logic        IOCS;
  logic        IORW;
  logic [1:0]  IOADDR;
  logic [7:0]  DATA;
  logic        TxD;
  logic        TBR;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int en_period = 1;
  bit en_rand   = 1'b0;

  // Line model: a frame is FRAME Enable ticks long starting at the transfer edge.
  bit       m_active;
  int       m_cnt;
  bit [7:0] m_byte;
  bit       m_pend;
  bit [7:0] m_pend_byte;

  spart_transmit #(
    .DATA_BITS (DB),
    .OVERSAMPLE(OS)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .Enable(Enable),
    .IOCS  (IOCS),
    .IORW  (IORW),
    .IOADDR(IOADDR),
    .DATA  (DATA),
    .TxD   (TxD),
    .TBR   (TBR)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d, t=%0t)", tag, got, exp, cyc, $time);
    end
  endtask

  task automatic model_reset();
    m_active    = 1'b0;
    m_cnt       = 0;
    m_byte      = '0;
    m_pend      = 1'b0;
    m_pend_byte = '0;
  endtask

  // Advance the model by one clock edge given the inputs sampled there.
  task automatic model_step(input bit wr, input bit [7:0] d, input bit en);
    bit old_pend;
    old_pend = m_pend;
    if (m_active) begin
      if (en) begin
        m_cnt++;
        if (m_cnt == FRAME) begin
          if (old_pend) begin
            m_byte = m_pend_byte;
            m_cnt  = 0;
            m_pend = 1'b0;
          end else begin
            m_active = 1'b0;
          end
        end
      end
    end else if (old_pend) begin
      m_active = 1'b1;
      m_byte   = m_pend_byte;
      m_cnt    = 0;
      m_pend   = 1'b0;
    end
    if (wr && !old_pend) begin
      m_pend      = 1'b1;
      m_pend_byte = d;
    end
  endtask

  function automatic logic exp_txd();
    int b;
    if (!m_active) return 1'b1;
    b = m_cnt / OS;
    if (b == 0) return 1'b0;
    if (b <= DB) return m_byte[b-1];
    return 1'b1;
  endfunction

  // One clock: drive bus inputs, step the model at the edge, compare #1 later.
  task automatic cycle(input logic cs, input logic rw, input logic [1:0] addr,
                       input logic [7:0] d);
    IOCS   = cs;
    IORW   = rw;
    IOADDR = addr;
    DATA   = d;
    if (en_rand) Enable = 1'($urandom_range(0, 1));
    else         Enable = ((cyc % en_period) == 0);
    @(posedge clk);
    cyc++;
    model_step(cs & ~rw & (addr == 2'b00), d, Enable);
    #1;
    check("txd", TxD, exp_txd());
    check("tbr", TBR, !m_pend);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 2'b00, 8'h00);
  endtask

  task automatic wr_byte(input logic [7:0] b);
    cycle(1'b1, 1'b0, 2'b00, b);
  endtask

  task automatic wait_tbr();
    int k;
    k = 0;
    while (TBR !== 1'b1 && k < 2000) begin
      idle(1);
      k++;
    end
    check("tbr_wait", TBR, 1'b1);
  endtask

  // Async reset applied between edges; outputs must go idle before any clock edge.
  task automatic apply_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check("rst_txd", TxD, 1'b1);
    check("rst_tbr", TBR, 1'b1);
    @(posedge clk);
    #1;
    check("rst_hold_txd", TxD, 1'b1);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst    = 1'b1;
    Enable = 1'b0;
    IOCS   = 1'b0;
    IORW   = 1'b0;
    IOADDR = 2'b00;
    DATA   = 8'h00;
    model_reset();
    #12;
    check("reset_txd", TxD, 1'b1);
    check("reset_tbr", TBR, 1'b1);
    rst = 1'b0;
    idle(4);

    // Single frame, Enable high.
    wr_byte(8'hA5);
    idle(FRAME + 30);

    // Back-to-back frames.
    wr_byte(8'h55);
    wait_tbr();
    wr_byte(8'hAA);
    idle(2 * FRAME + 20);

    // Third write while the holding register is full is dropped.
    wr_byte(8'h11);
    wait_tbr();
    wr_byte(8'h22);
    wr_byte(8'h33);
    idle(2 * FRAME + 20);

    // Enable every 4th clock.
    en_period = 4;
    wr_byte(8'h3C);
    idle(4 * FRAME + 40);
    en_period = 1;

    // Reset mid-frame with a byte queued.
    wr_byte(8'hFF);
    wait_tbr();
    wr_byte(8'h81);
    idle(48);
    apply_reset();
    idle(FRAME + 40);

    // Reads and other addresses must not load the buffer.
    cycle(1'b1, 1'b1, 2'b00, 8'h5A);
    cycle(1'b1, 1'b0, 2'b01, 8'h5A);
    cycle(1'b1, 1'b0, 2'b10, 8'h5A);
    cycle(1'b1, 1'b0, 2'b11, 8'h5A);
    cycle(1'b0, 1'b0, 2'b00, 8'h5A);
    idle(FRAME);

    // Random bus traffic with random Enable.
    en_rand = 1'b1;
    for (int i = 0; i < 6000; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 8) begin
        cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              2'($urandom_range(0, 3)), 8'($urandom));
      end else if (r < 20) begin
        wr_byte(8'($urandom));
      end else if (r == 20 && $urandom_range(0, 19) == 0) begin
        apply_reset();
      end else begin
        idle(1);
      end
    end
    en_rand = 1'b0;
    idle(FRAME + 20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
